// File: rtl/led_pkg.sv
// led_pkg -- shared constants for the LED panel scan controller.
//   Scan-state encodings (legacy-compatible localparams), default
//   geometry/timing parameters and a row-address width helper.
package led_pkg;

   // Default geometry and timing
   localparam int COLS_DEF      = 64;
   localparam int ROWS_DEF      = 16;
   localparam int PWM_MAX_DEF   = 254;
   localparam int PIPE_SKIP_DEF = 2;

   // Scan FSM state encodings
   localparam logic [2:0] ST_RRST    = 3'd0;
   localparam logic [2:0] ST_SHIFT   = 3'd1;
   localparam logic [2:0] ST_BLANK   = 3'd2;
   localparam logic [2:0] ST_LATCH   = 3'd3;
   localparam logic [2:0] ST_UNBLANK = 3'd4;

   // Row address width; a single-row panel still gets a 1-bit address.
   function automatic int addr_width(input int rows);
      return (rows > 1) ? $clog2(rows) : 1;
   endfunction

endpackage

// File: rtl/led_triad_timer.sv
// led_triad_timer -- per-state triad counter with pipeline-skip and pixel index.
//   Ports:
//     clk, rst       clock, synchronous active-high reset
//     strobe         triad-start strobe (receiver phase 0)
//     restart        the incoming triad is the first of a new state
//     shift_next     the incoming triad belongs to SHIFT
//     pixel          this strobe carries a pixel to shift out
//     read_slot      incoming triad is within the first COLS triads of its state
//     line_done      the last pixel of the line has been accepted
module led_triad_timer
   import led_pkg::*;
#(
   parameter int COLS      = COLS_DEF,
   parameter int PIPE_SKIP = PIPE_SKIP_DEF,
   localparam int TW       = $clog2(COLS + PIPE_SKIP + 1),
   localparam int CW       = (COLS > 1) ? $clog2(COLS) : 1
) (
   input  logic clk,
   input  logic rst,
   input  logic strobe,
   input  logic restart,
   input  logic shift_next,
   output logic pixel,
   output logic read_slot,
   output logic line_done
);

   logic [TW-1:0] triad;
   logic [TW-1:0] next_triad;
   logic [CW-1:0] col;

   // Index of the triad the current strobe opens, and whether it carries a pixel.
   always_comb begin
      next_triad = '0;
      pixel      = 1'b0;
      read_slot  = 1'b0;
      if (restart) begin
         next_triad = '0;
      end else begin
         next_triad = triad + TW'(1);
      end
      // The first PIPE_SKIP strobes of a line only flush the upstream pipeline.
      if (strobe && shift_next && (next_triad >= TW'(PIPE_SKIP))) begin
         pixel = 1'b1;
      end else begin
         pixel = 1'b0;
      end
      if (next_triad < TW'(COLS)) begin
         read_slot = 1'b1;
      end else begin
         read_slot = 1'b0;
      end
   end

   // Triad index, column index and end-of-line flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         triad     <= '0;
         col       <= '0;
         line_done <= 1'b0;
      end else begin
         if (strobe) begin
            triad <= next_triad;
         end
         if (pixel) begin
            col <= (col == CW'(COLS - 1)) ? '0 : col + CW'(1);
         end
         // Flag stays set until the strobe that leaves SHIFT.
         if (pixel && (col == CW'(COLS - 1))) begin
            line_done <= 1'b1;
         end else if (strobe && restart) begin
            line_done <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl -- HUB75-style LED panel scan controller fed by an AL422 FIFO.
//   Steps RRST -> SHIFT -> BLANK -> LATCH -> UNBLANK once per row, advancing
//   only on triad boundaries (the 3 cycles opened by pwm_cntr_strobe).
//   Ports:
//     in_clk, in_rst     clock, synchronous active-high reset
//     pwm_cntr_strobe    receiver phase-0 strobe (rgb1_in valid)
//     alrst_strobe       receiver phase-1 strobe (AL422 read-reset slot)
//     rgb1_in[2:0]       pixel bits from the receiver
//     pwm_value[7:0]     PWM threshold back to the receiver, +1 per frame
//     panel_rgb/clk/lat/oe_n/addr   panel drive (oe_n active-low)
//     al_re_n, al_rrst_n AL422 read enable / read reset, active-low
//     frame_done         one-cycle pulse at the end of each frame pass
module led_scan_ctrl
   import led_pkg::*;
#(
   parameter int COLS      = COLS_DEF,
   parameter int ROWS      = ROWS_DEF,
   parameter int PWM_MAX   = PWM_MAX_DEF,
   parameter int PIPE_SKIP = PIPE_SKIP_DEF,
   localparam int AW       = addr_width(ROWS)
) (
   input  logic          in_clk,
   input  logic          in_rst,
   input  logic          pwm_cntr_strobe,
   input  logic          alrst_strobe,
   input  logic [2:0]    rgb1_in,
   output logic [7:0]    pwm_value,
   output logic [2:0]    panel_rgb,
   output logic          panel_clk,
   output logic          panel_lat,
   output logic          panel_oe_n,
   output logic [AW-1:0] panel_addr,
   output logic          al_re_n,
   output logic          al_rrst_n,
   output logic          frame_done
);

   logic [2:0]    state;
   logic [2:0]    next_state;
   logic [AW-1:0] row;
   logic          row_last;
   logic          restart;
   logic          pixel;
   logic          read_slot;
   logic          line_done;
   logic          clk_pending;

   assign row_last = (row == AW'(ROWS - 1));
   // A strobe that ends a state is the first strobe of the next one.
   assign restart  = (next_state != state);

   led_triad_timer #(
      .COLS      (COLS),
      .PIPE_SKIP (PIPE_SKIP)
   ) u_timer (
      .clk        (in_clk),
      .rst        (in_rst),
      .strobe     (pwm_cntr_strobe),
      .restart    (restart),
      .shift_next (next_state == ST_SHIFT),
      .pixel      (pixel),
      .read_slot  (read_slot),
      .line_done  (line_done)
   );

   // State the next triad belongs to; only taken when a strobe arrives.
   always_comb begin
      next_state = state;
      case (state)
         ST_RRST:    next_state = ST_SHIFT;
         ST_SHIFT: begin
            if (line_done) begin
               next_state = ST_BLANK;
            end else begin
               next_state = ST_SHIFT;
            end
         end
         ST_BLANK:   next_state = ST_LATCH;
         ST_LATCH:   next_state = ST_UNBLANK;
         ST_UNBLANK: begin
            if (row_last) begin
               next_state = ST_RRST;
            end else begin
               next_state = ST_SHIFT;
            end
         end
         default:    next_state = ST_RRST;
      endcase
   end

   // Scan state, row/frame bookkeeping and all registered panel/FIFO outputs.
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         state       <= ST_RRST;
         row         <= '0;
         pwm_value   <= 8'd0;
         panel_addr  <= '0;
         panel_rgb   <= 3'd0;
         panel_clk   <= 1'b0;
         panel_lat   <= 1'b0;
         panel_oe_n  <= 1'b1;
         al_re_n     <= 1'b1;
         al_rrst_n   <= 1'b1;
         frame_done  <= 1'b0;
         clk_pending <= 1'b0;
      end else begin
         // Pixel lands on panel_rgb one cycle after its strobe, clock edge one after that.
         clk_pending <= pixel;
         panel_clk   <= clk_pending;
         panel_lat   <= 1'b0;
         frame_done  <= 1'b0;
         al_rrst_n   <= ~((state == ST_RRST) && alrst_strobe);
         if (pixel) begin
            panel_rgb <= rgb1_in;
         end
         if (pwm_cntr_strobe) begin
            state      <= next_state;
            al_re_n    <= ~((next_state == ST_SHIFT) && read_slot);
            // Outputs stay enabled while shifting so the previous row keeps showing.
            panel_oe_n <= (next_state == ST_BLANK) || (next_state == ST_LATCH);
            if ((state == ST_BLANK) && (next_state == ST_LATCH)) begin
               panel_lat  <= 1'b1;
               panel_addr <= row;
            end
            if (state == ST_UNBLANK) begin
               if (row_last) begin
                  row        <= '0;
                  frame_done <= 1'b1;
                  pwm_value  <= (pwm_value == 8'(PWM_MAX)) ? 8'd0 : pwm_value + 8'd1;
               end else begin
                  row <= row + AW'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// tb_led_scan_ctrl -- directed, table-driven bench for led_scan_ctrl
//   (COLS=4, ROWS=2, PIPE_SKIP=2) with a free-running 3-phase strobe source.
module tb_led_scan_ctrl;

   logic       in_clk = 1'b0;
   logic       in_rst = 1'b1;
   logic       pwm_cntr_strobe = 1'b0;
   logic       alrst_strobe = 1'b0;
   logic [2:0] rgb1_in = 3'd0;
   logic [7:0] pwm_value;
   logic [2:0] panel_rgb;
   logic       panel_clk;
   logic       panel_lat;
   logic       panel_oe_n;
   logic       panel_addr;
   logic       al_re_n;
   logic       al_rrst_n;
   logic       frame_done;

   int n_pass  = 0;
   int n_total = 0;
   int phase   = 0;
   int n_clk, n_lat, n_fd, n_re, n_oe, n_rrst, n_rrst_ok;
   logic lat_addr;

   typedef struct {
      logic        rst;
      logic        ps;
      logic        as;
      logic [2:0]  rgb;
      logic [17:0] exp;   // {pwm, fd, addr, rrst_n, re_n, oe_n, lat, clk, rgb}
   } vec_t;

   vec_t vq[$];

   led_scan_ctrl #(
      .COLS      (4),
      .ROWS      (2),
      .PWM_MAX   (254),
      .PIPE_SKIP (2)
   ) dut (
      .in_clk          (in_clk),
      .in_rst          (in_rst),
      .pwm_cntr_strobe (pwm_cntr_strobe),
      .alrst_strobe    (alrst_strobe),
      .rgb1_in         (rgb1_in),
      .pwm_value       (pwm_value),
      .panel_rgb       (panel_rgb),
      .panel_clk       (panel_clk),
      .panel_lat       (panel_lat),
      .panel_oe_n      (panel_oe_n),
      .panel_addr      (panel_addr),
      .al_re_n         (al_re_n),
      .al_rrst_n       (al_rrst_n),
      .frame_done      (frame_done)
   );

   always #5 in_clk = ~in_clk;

   function automatic logic [17:0] outs();
      return {pwm_value, frame_done, panel_addr, al_rrst_n, al_re_n,
              panel_oe_n, panel_lat, panel_clk, panel_rgb};
   endfunction

   function automatic vec_t mk(input int rst, input int ps, input int as, input int rgb,
                               input int clk, input int lat, input int oe, input int re,
                               input int rrst, input int addr, input int prgb);
      vec_t v;
      v.rst = 1'(rst);
      v.ps  = 1'(ps);
      v.as  = 1'(as);
      v.rgb = 3'(rgb);
      v.exp = {8'd0, 1'b0, 1'(addr), 1'(rrst), 1'(re), 1'(oe), 1'(lat), 1'(clk), 3'(prgb)};
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
   endtask

   task automatic clear_mon();
      n_clk = 0; n_lat = 0; n_fd = 0; n_re = 0; n_oe = 0; n_rrst = 0; n_rrst_ok = 0;
      lat_addr = 1'b0;
   endtask

   // One clock of the free-running receiver model plus output bookkeeping.
   task automatic cycle();
      pwm_cntr_strobe = (phase == 0);
      alrst_strobe    = (phase == 1);
      @(posedge in_clk);
      #1;
      if (panel_clk) n_clk++;
      if (panel_lat) begin
         n_lat++;
         lat_addr = panel_addr;
      end
      if (frame_done) n_fd++;
      if (!al_re_n) n_re++;
      if (panel_oe_n) n_oe++;
      if (!al_rrst_n) begin
         n_rrst++;
         if (alrst_strobe) n_rrst_ok++;
      end
      phase = (phase + 1) % 3;
   endtask

   initial begin
      // rst ps as rgb | clk lat oe re rrst addr prgb
      vq.push_back(mk(1,0,0,0, 0,0,1,1,1,0,0));   // reset
      vq.push_back(mk(1,0,0,0, 0,0,1,1,1,0,0));
      vq.push_back(mk(0,1,0,1, 0,0,0,0,1,0,0));   // RRST -> SHIFT, skip 1
      vq.push_back(mk(0,0,1,1, 0,0,0,0,1,0,0));
      vq.push_back(mk(0,0,0,1, 0,0,0,0,1,0,0));
      vq.push_back(mk(0,1,0,2, 0,0,0,0,1,0,0));   // skip 2
      vq.push_back(mk(0,0,1,2, 0,0,0,0,1,0,0));
      vq.push_back(mk(0,0,0,2, 0,0,0,0,1,0,0));
      vq.push_back(mk(0,1,0,3, 0,0,0,0,1,0,3));   // pixel col 0
      vq.push_back(mk(0,0,1,3, 1,0,0,0,1,0,3));
      vq.push_back(mk(0,0,0,3, 0,0,0,0,1,0,3));
      vq.push_back(mk(0,1,0,4, 0,0,0,0,1,0,4));   // col 1
      vq.push_back(mk(0,0,1,4, 1,0,0,0,1,0,4));
      vq.push_back(mk(0,0,0,4, 0,0,0,0,1,0,4));
      vq.push_back(mk(0,1,0,5, 0,0,0,1,1,0,5));   // col 2, read window closed
      vq.push_back(mk(0,0,1,5, 1,0,0,1,1,0,5));
      vq.push_back(mk(0,0,0,5, 0,0,0,1,1,0,5));
      vq.push_back(mk(0,1,0,6, 0,0,0,1,1,0,6));   // col 3
      vq.push_back(mk(0,0,1,6, 1,0,0,1,1,0,6));
      vq.push_back(mk(0,0,0,6, 0,0,0,1,1,0,6));
      vq.push_back(mk(0,1,0,7, 0,0,1,1,1,0,6));   // BLANK
      vq.push_back(mk(0,0,1,7, 0,0,1,1,1,0,6));
      vq.push_back(mk(0,0,0,7, 0,0,1,1,1,0,6));
      vq.push_back(mk(0,1,0,7, 0,1,1,1,1,0,6));   // LATCH, addr 0
      vq.push_back(mk(0,0,1,7, 0,0,1,1,1,0,6));
      vq.push_back(mk(0,0,0,7, 0,0,1,1,1,0,6));
      vq.push_back(mk(0,1,0,7, 0,0,0,1,1,0,6));   // UNBLANK
      vq.push_back(mk(0,0,1,7, 0,0,0,1,1,0,6));
      vq.push_back(mk(0,0,0,7, 0,0,0,1,1,0,6));
      vq.push_back(mk(0,1,0,7, 0,0,0,0,1,0,6));   // SHIFT line 1

      foreach (vq[i]) begin
         in_rst          = vq[i].rst;
         pwm_cntr_strobe = vq[i].ps;
         alrst_strobe    = vq[i].as;
         rgb1_in         = vq[i].rgb;
         @(posedge in_clk);
         #1;
         check($sformatf("vec%0d", i), 32'(outs()), 32'(vq[i].exp));
      end
      phase = 1;

      // Rest of frame 0: line 1, then frame end and AL422 read reset.
      clear_mon();
      repeat (29) cycle();
      check("f0_clk_pulses", n_clk, 4);
      check("f0_lat_pulses", n_lat, 1);
      check("f0_lat_addr", 32'(lat_addr), 1);
      check("f0_oe_high", n_oe, 6);
      check("f0_frame_done", n_fd, 1);
      check("f0_rrst_cycles", n_rrst, 1);
      check("f0_rrst_slot", n_rrst_ok, 1);
      check("f0_pwm", 32'(pwm_value), 1);

      // One full frame.
      clear_mon();
      repeat (57) cycle();
      check("f1_clk_pulses", n_clk, 8);
      check("f1_re_low", n_re, 24);
      check("f1_lat_pulses", n_lat, 2);
      check("f1_oe_high", n_oe, 12);
      check("f1_frame_done", n_fd, 1);
      check("f1_rrst_slot", n_rrst_ok, 1);
      check("f1_pwm", 32'(pwm_value), 2);

      // Reset while col 2 is on its way to the panel.
      clear_mon();
      repeat (13) cycle();
      check("mid_clk_pulses", n_clk, 2);
      in_rst = 1'b1;
      cycle();
      check("mid_reset_outs", 32'(outs()), 32'({8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0}));
      in_rst = 1'b0;
      clear_mon();
      repeat (2) cycle();
      check("post_rst_no_clk", n_clk + n_lat, 0);
      check("post_rst_reentry", 32'({al_re_n, panel_oe_n}), 0);

      // Frames from reset until the PWM threshold wraps.
      clear_mon();
      repeat (57) cycle();
      check("w0_clk_pulses", n_clk, 8);
      check("w0_frame_done", n_fd, 1);
      repeat (253 * 57) cycle();
      check("pwm_at_max", 32'(pwm_value), 254);
      clear_mon();
      repeat (57) cycle();
      check("pwm_wrap", 32'(pwm_value), 0);
      check("wrap_frame_done", n_fd, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
